// File: rtl/e_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e_updown_counter_pkg
// Description : Shared constants for the up/down counter family.
//               Direction and bound-handling encodings. Both are single-bit
//               control inputs, so the constants are one bit wide.
// Revision    : 1.0 - initial release
// ============================================================================
package e_updown_counter_pkg;

    // Direction encoding for dir_i
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    // Bound handling encoding for sat_i
    localparam logic c_MODE_WRAP = 1'b0;
    localparam logic c_MODE_SAT  = 1'b1;

    // Supported WIDTH range
    localparam int c_WIDTH_MIN = 1;
    localparam int c_WIDTH_MAX = 32;

endpackage : e_updown_counter_pkg
`default_nettype wire

// File: rtl/e_updown_counter_next.sv
`default_nettype none
// ============================================================================
// Module      : e_updown_counter_next
// Description : Purely combinational next-state logic for e_updown_counter.
//               Given the current count and the controls sampled this cycle,
//               produces the next count and the next wrap flag. Reset is not
//               handled here; the register stage applies it with top priority.
// Ports       : i_count      - current count
//               i_max        - inclusive upper bound
//               i_dir        - 0 up, 1 down
//               i_sat        - 0 wrap, 1 saturate
//               i_en         - count enable
//               i_load       - load strobe (beats i_en)
//               i_load_value - value to load (clamped to i_max)
//               o_count_next - next count
//               o_wrap_next  - next wrap flag
// Revision    : 1.0 - initial release
// ============================================================================
module e_updown_counter_next
    import e_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_max,
    input  logic             i_dir,
    input  logic             i_sat,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count_next,
    output logic             o_wrap_next
);

    logic w_at_or_above_max;  // count >= max: up step hits the bound
    logic w_above_max;        // count > max: max was lowered under us
    logic w_is_zero;          // count == 0: down step hits the bound
    logic [WIDTH-1:0] w_load_clamped;

    // All comparisons are made on the current value before any arithmetic,
    // so with max = all-ones the up step never relies on the adder overflow.
    assign w_at_or_above_max = (i_count >= i_max);
    assign w_above_max       = (i_count >  i_max);
    assign w_is_zero         = (i_count == '0);
    assign w_load_clamped    = (i_load_value > i_max) ? i_max : i_load_value;

    always_comb begin
        o_count_next = i_count;
        o_wrap_next  = 1'b0;

        if (i_load) begin
            o_count_next = w_load_clamped;
        end else if (i_en) begin
            if (i_dir == c_DIR_UP) begin
                if (!w_at_or_above_max) begin
                    o_count_next = i_count + 1'b1;
                end else if (i_sat == c_MODE_SAT) begin
                    o_count_next = i_max;
                end else begin
                    o_count_next = '0;
                    o_wrap_next  = 1'b1;
                end
            end else begin
                if (w_above_max) begin
                    // Clamp down to a lowered bound; not a wrap event.
                    o_count_next = i_max;
                end else if (!w_is_zero) begin
                    o_count_next = i_count - 1'b1;
                end else if (i_sat == c_MODE_SAT) begin
                    o_count_next = '0;
                end else begin
                    o_count_next = i_max;
                    o_wrap_next  = 1'b1;
                end
            end
        end
    end

endmodule : e_updown_counter_next
`default_nettype wire

// File: rtl/e_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : e_updown_counter
// Description : Parametrised up/down counter with enable, wrap-or-saturate
//               bound handling, synchronous parallel load and terminal-count
//               flags. Count range is [0, max_i] inclusive.
// Ports       : clk_i        - clock, rising edge
//               rst_i        - synchronous active-high reset
//               en_i         - count enable
//               dir_i        - 0 up, 1 down
//               sat_i        - 0 wrap, 1 saturate
//               load_i       - synchronous load strobe
//               load_value_i - value to load (clamped to max_i)
//               max_i        - inclusive upper bound, may change any time
//               output__     - registered count
//               wrap_o       - registered pulse on a wrapped value
//               at_max_o     - combinational output__ == max_i
//               at_zero_o    - combinational output__ == 0
// Revision    : 1.0 - initial release
// ============================================================================
module e_updown_counter
    import e_updown_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             sat_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] output__,
    output logic             wrap_o,
    output logic             at_max_o,
    output logic             at_zero_o
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             r_wrap_q;
    logic             w_wrap_d;

    e_updown_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count      (r_count_q),
        .i_max        (max_i),
        .i_dir        (dir_i),
        .i_sat        (sat_i),
        .i_en         (en_i),
        .i_load       (load_i),
        .i_load_value (load_value_i),
        .o_count_next (w_count_d),
        .o_wrap_next  (w_wrap_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count_q <= '0;
            r_wrap_q  <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_wrap_q  <= w_wrap_d;
        end
    end

    assign output__  = r_count_q;
    assign wrap_o    = r_wrap_q;
    // Live compare against max_i so the flag tracks bound changes immediately.
    assign at_max_o  = (r_count_q == max_i);
    assign at_zero_o = (r_count_q == '0);

endmodule : e_updown_counter
`default_nettype wire
